// File: rtl/alu_seq_unit.sv
// alu_seq_unit: multi-cycle RV32I ALU with iterative shifts and optional MUL.
// Sits between decode/regfile read and writeback behind valid/ready handshakes.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   in_valid, in_ready     operand handshake (in_ready high only while idle)
//   op[3:0], a, b          opcode and operands, captured on accept
//   out_valid, out_ready   result handshake (result held until taken)
//   result, zero, err      registered result, result==0 flag, illegal-op flag
module alu_seq_unit #(
    parameter  int WIDTH   = 32,
    parameter  bit MUL_EN  = 1'b1,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             err
);

    localparam int CNT_W = SHAMT_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        SHIFT,
        MULT,
        DONE
    } state_t;

    state_t             state;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   acc;
    logic [CNT_W-1:0]   cnt;

    logic [SHAMT_W-1:0] shamt_in;
    logic               is_shift;
    logic               go_mul;
    logic               go_shift;

    logic [WIDTH-1:0]   exec_res;
    logic               exec_err;
    logic [WIDTH-1:0]   shift_nxt;
    logic [WIDTH-1:0]   acc_nxt;

    assign in_ready = (state == IDLE);

    assign shamt_in = b[SHAMT_W-1:0];
    assign is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    assign go_mul   = (op == OP_MUL) && MUL_EN;
    // A zero shift amount takes the single-cycle path and returns a.
    assign go_shift = is_shift && (shamt_in != '0);

    // Single-cycle ops, evaluated on the captured operands in EXEC.
    always_comb begin
        exec_res = '0;
        exec_err = 1'b0;
        case (op_q)
            OP_ADD:  exec_res = a_q + b_q;
            OP_SUB:  exec_res = a_q - b_q;
            OP_AND:  exec_res = a_q & b_q;
            OP_OR:   exec_res = a_q | b_q;
            OP_XOR:  exec_res = a_q ^ b_q;
            OP_SLT:  exec_res = {{(WIDTH-1){1'b0}},
                                 ($signed(a_q) < $signed(b_q))};
            OP_SLTU: exec_res = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
            OP_SLL,
            OP_SRL,
            OP_SRA:  exec_res = a_q;
            // Only reaches EXEC when the multiplier is not built.
            OP_MUL:  exec_err = 1'b1;
            default: exec_err = 1'b1;
        endcase
    end

    always_comb begin
        shift_nxt = a_q;
        case (op_q)
            OP_SLL:  shift_nxt = a_q << 1;
            OP_SRL:  shift_nxt = a_q >> 1;
            OP_SRA:  shift_nxt = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
            default: shift_nxt = a_q;
        endcase
    end

    // Radix-2 shift-add: a_q is the multiplicand shifted left each step,
    // b_q the multiplier shifted right; only the low WIDTH bits are kept.
    assign acc_nxt = b_q[0] ? (acc + a_q) : acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            err       <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q <= op;
                        a_q  <= a;
                        b_q  <= b;
                        acc  <= '0;
                        unique case (1'b1)
                            go_mul: begin
                                cnt   <= CNT_FULL;
                                state <= MULT;
                            end
                            go_shift: begin
                                cnt   <= {1'b0, shamt_in};
                                state <= SHIFT;
                            end
                            default: begin
                                cnt   <= '0;
                                state <= EXEC;
                            end
                        endcase
                    end
                end
                EXEC: begin
                    result    <= exec_res;
                    zero      <= (exec_res == '0);
                    err       <= exec_err;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                SHIFT: begin
                    a_q <= shift_nxt;
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        result    <= shift_nxt;
                        zero      <= (shift_nxt == '0);
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                MULT: begin
                    acc <= acc_nxt;
                    a_q <= a_q << 1;
                    b_q <= b_q >> 1;
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        result    <= acc_nxt;
                        zero      <= (acc_nxt == '0);
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: directed self-checking bench for alu_seq_unit.
// Second instance built with MUL_EN=0 for the illegal-MUL case.
module tb_alu_seq_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        err;

    logic        v0;
    logic        ir0;
    logic        ov0;
    logic        rdy0;
    logic [31:0] res0;
    logic        z0;
    logic        e0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq_unit #(.WIDTH(32), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .err(err)
    );

    alu_seq_unit #(.WIDTH(32), .MUL_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v0), .in_ready(ir0),
        .op(op), .a(a), .b(b),
        .out_valid(ov0), .out_ready(rdy0),
        .result(res0), .zero(z0), .err(e0)
    );

    // Issue one op to dut and return edges from accept to out_valid
    // (-1 if the result never appears).
    task automatic run_op(input logic [3:0] o, input logic [31:0] x,
                          input logic [31:0] y, output int lat);
        @(negedge clk);
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int seen;
        rst_n = 1'b0;
        in_valid = 1'b0;
        v0 = 1'b0;
        out_ready = 1'b1;
        rdy0 = 1'b1;
        op = '0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0
            || zero !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_init got rdy=%b ov=%b res=%h z=%b e=%b want 1 0 0 0 0",
                     in_ready, out_valid, result, zero, err);
        end
        // Reset in the middle of a MUL discards it.
        @(negedge clk);
        in_valid = 1'b1;
        op = 4'b1010;
        a = 32'h0001_0001;
        b = 32'h0001_0001;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mul_busy got in_ready=%b want 0", in_ready);
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0
            || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_mul got rdy=%b ov=%b res=%h e=%b want 1 0 0 0",
                     in_ready, out_valid, result, err);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_discard got %0d valid cycles want 0", seen);
        end
    endtask

    task automatic test_arith;
        int lat;
        run_op(4'b0000, 32'hFFFF_FFFF, 32'h1, lat);
        checks++;
        if (lat !== 1 || result !== 32'h0 || zero !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL add_wrap got lat=%0d res=%h z=%b e=%b want 1 00000000 1 0",
                     lat, result, zero, err);
        end
        run_op(4'b0001, 32'd5, 32'd7, lat);
        checks++;
        if (lat !== 1 || result !== 32'hFFFF_FFFE || zero !== 1'b0) begin
            errors++;
            $display("FAIL sub got lat=%0d res=%h z=%b want 1 fffffffe 0",
                     lat, result, zero);
        end
        run_op(4'b0010, 32'hF0F0_F0F0, 32'hFF00_FF00, lat);
        checks++;
        if (lat !== 1 || result !== 32'hF000_F000) begin
            errors++;
            $display("FAIL and got lat=%0d res=%h want 1 f000f000", lat, result);
        end
        run_op(4'b0011, 32'hF0F0_F0F0, 32'hFF00_FF00, lat);
        checks++;
        if (lat !== 1 || result !== 32'hFFF0_FFF0) begin
            errors++;
            $display("FAIL or got lat=%0d res=%h want 1 fff0fff0", lat, result);
        end
        run_op(4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, lat);
        checks++;
        if (lat !== 1 || result !== 32'h0FF0_0FF0) begin
            errors++;
            $display("FAIL xor got lat=%0d res=%h want 1 0ff00ff0", lat, result);
        end
    endtask

    task automatic test_compare;
        int lat;
        run_op(4'b0101, 32'h8000_0000, 32'h1, lat);
        checks++;
        if (lat !== 1 || result !== 32'h1 || zero !== 1'b0) begin
            errors++;
            $display("FAIL slt got lat=%0d res=%h z=%b want 1 00000001 0",
                     lat, result, zero);
        end
        run_op(4'b0110, 32'h8000_0000, 32'h1, lat);
        checks++;
        if (lat !== 1 || result !== 32'h0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL sltu got lat=%0d res=%h z=%b want 1 00000000 1",
                     lat, result, zero);
        end
        run_op(4'b1111, 32'h1234_5678, 32'h9, lat);
        checks++;
        if (lat !== 1 || result !== 32'h0 || err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_f got lat=%0d res=%h e=%b want 1 00000000 1",
                     lat, result, err);
        end
        run_op(4'b1011, 32'h1, 32'h1, lat);
        checks++;
        if (lat !== 1 || result !== 32'h0 || err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_b got lat=%0d res=%h e=%b want 1 00000000 1",
                     lat, result, err);
        end
    endtask

    task automatic test_shift;
        int lat;
        run_op(4'b1001, 32'h8000_0000, 32'h24, lat);
        checks++;
        if (lat !== 4 || result !== 32'hF800_0000 || err !== 1'b0) begin
            errors++;
            $display("FAIL sra4 got lat=%0d res=%h e=%b want 4 f8000000 0",
                     lat, result, err);
        end
        run_op(4'b0111, 32'h1234_5678, 32'h20, lat);
        checks++;
        if (lat !== 1 || result !== 32'h1234_5678) begin
            errors++;
            $display("FAIL sll0 got lat=%0d res=%h want 1 12345678", lat, result);
        end
        run_op(4'b1000, 32'h8000_0001, 32'd31, lat);
        checks++;
        if (lat !== 31 || result !== 32'h1) begin
            errors++;
            $display("FAIL srl31 got lat=%0d res=%h want 31 00000001", lat, result);
        end
        run_op(4'b0111, 32'h0000_0003, 32'd31, lat);
        checks++;
        if (lat !== 31 || result !== 32'h8000_0000) begin
            errors++;
            $display("FAIL sll31 got lat=%0d res=%h want 31 80000000", lat, result);
        end
        run_op(4'b1001, 32'h4000_0000, 32'd2, lat);
        checks++;
        if (lat !== 2 || result !== 32'h1000_0000) begin
            errors++;
            $display("FAIL sra_pos got lat=%0d res=%h want 2 10000000", lat, result);
        end
    endtask

    task automatic test_mul;
        int lat;
        run_op(4'b1010, 32'h0001_0001, 32'h0001_0001, lat);
        checks++;
        if (lat !== 32 || result !== 32'h0002_0001 || err !== 1'b0) begin
            errors++;
            $display("FAIL mul got lat=%0d res=%h e=%b want 32 00020001 0",
                     lat, result, err);
        end
        run_op(4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        checks++;
        if (lat !== 32 || result !== 32'h1) begin
            errors++;
            $display("FAIL mul_neg got lat=%0d res=%h want 32 00000001", lat, result);
        end
        run_op(4'b1010, 32'd12345, 32'd0, lat);
        checks++;
        if (lat !== 32 || result !== 32'h0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL mul_zero got lat=%0d res=%h z=%b want 32 00000000 1",
                     lat, result, zero);
        end
        // Multiplier absent: MUL must be flagged illegal in one cycle.
        @(negedge clk);
        for (int i = 0; i < 50 && !ir0; i++) @(negedge clk);
        op = 4'b1010;
        a = 32'h0001_0001;
        b = 32'h0001_0001;
        v0 = 1'b1;
        @(posedge clk);
        #1;
        v0 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (ov0) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat !== 1 || res0 !== 32'h0 || e0 !== 1'b1) begin
            errors++;
            $display("FAIL mul_disabled got lat=%0d res=%h e=%b want 1 00000000 1",
                     lat, res0, e0);
        end
    endtask

    task automatic test_backpressure;
        int lat;
        int bad;
        out_ready = 1'b0;
        run_op(4'b0000, 32'd3, 32'd4, lat);
        checks++;
        if (lat !== 1 || result !== 32'd7) begin
            errors++;
            $display("FAIL bp_add got lat=%0d res=%h want 1 00000007", lat, result);
        end
        // A new request while busy must be ignored.
        in_valid = 1'b1;
        op = 4'b0001;
        a = 32'd100;
        b = 32'd1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'd7
                || zero !== 1'b0 || err !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL bp_hold got %0d unstable cycles want 0", bad);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got ov=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL bp_noqueue got %0d valid cycles want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_compare();
        test_shift();
        test_mul();
        test_backpressure();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
